uart_rx_deframer: RTL
=====================

Name: uart_rx_deframer

Overview:
Receive-side counterpart of the UART transmit path. It recovers 8N1-style frames from the asynchronous serial line. It oversamples the line on an external oversample tick, validates the start bit at mid-bit, samples each data bit at its centre (LSB first) and checks the stop bit. Each completed byte is presented with a one-cycle valid pulse to the downstream consumer, such as an RX FIFO or register file.

Parameters:
DATA_BITS, 8, data bits per frame (5..9)
OVERSAMPLE, 16, os_tick pulses per bit interval (even, >=8)
PARITY_ODD, 0, parity sense when UART_RX_PARITY_EN is defined: 0 = even, 1 = odd

Ports:
clk  input  1  system clock
arst_n  input  1  asynchronous active-low reset
os_tick  input  1  1-cycle pulse, OVERSAMPLE per baud interval
rx  input  1  asynchronous serial line, idle high
rx_data  output  DATA_BITS  last received data word
rx_valid  output  1  1-cycle pulse: good frame in rx_data
frame_err  output  1  1-cycle pulse: stop bit sampled low
parity_err  output  1  1-cycle pulse: parity mismatch (tied 0 without feature)
busy  output  1  high from start-bit detection until frame end

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on arst_n.
- Reset values: state=IDLE, rx_data=0, rx_valid=0, frame_err=0, parity_err=0, busy=0, tick_cnt=0, bit_cnt=0, shift reg=0.
- Synchronizer: 2-flop synchronizer on rx, with both flops reset to 1. All decisions use the synchronized value rx_s.
- Sequential logic: tick_cnt and bit_cnt advance only on cycles where os_tick=1. All other state holds between ticks.
- IDLE: busy=0. On os_tick with rx_s=0, go to START with tick_cnt=0 and busy=1.
- START: on each os_tick, increment tick_cnt. When tick_cnt==OVERSAMPLE/2-1:
  - rx_s=0: go to DATA with tick_cnt=0 and bit_cnt=0. Sampling is now aligned to bit centre.
  - rx_s=1: treat as a glitch and return to IDLE with busy=0. No pulse is raised.
- DATA: when tick_cnt==OVERSAMPLE-1, sample rx_s and shift it in from the MSB side (LSB-first line order). Reset tick_cnt and increment bit_cnt. After the sample with bit_cnt==DATA_BITS-1, go to STOP, or to PARITY if the feature is enabled.
- STOP: when tick_cnt==OVERSAMPLE-1, sample rx_s, then:
  - rx_data <= shift reg, in both cases.
  - rx_s=1: rx_valid=1 for exactly one cycle.
  - rx_s=0: frame_err=1 for exactly one cycle and rx_valid stays 0.
  - In the same cycle, return to IDLE with busy=0.
- Early return: IDLE is re-entered at the stop-bit centre. A start edge arriving half a bit later is detected, so back-to-back frames are supported.
- Stuck-low line: if frame_err fired and the line is still low, the next os_tick re-enters START. The glitch filter rejects it only if the line goes high; otherwise a new frame begins. This is required, not an error.
- Latency: the pulse appears in the cycle after the os_tick of the stop-bit sample. Roughly (DATA_BITS+1.5) bit times plus 3 clk from the start-bit falling edge.
- os_tick absent: the FSM holds indefinitely.
- Output pulses: rx_valid, frame_err and parity_err are never asserted together. rx_valid is suppressed whenever frame_err or parity_err is raised.
- Reset mid-frame: immediate return to reset values. A partial frame is discarded with no pulse.

Optional Feature:
UART_RX_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP. It samples at the bit centre and compares against the XOR of the data bits, XOR PARITY_ODD.
  - Mismatch with a good stop bit: parity_err pulses instead of rx_valid.
  - Stop bit low: frame_err takes priority.
- Undefined: no PARITY state and parity_err is constant 0.

Decomposition:
- Package uart_pkg: FSM state encoding (IDLE, START, DATA, PARITY, STOP), default DATA_BITS and OVERSAMPLE constants, and the width of tick_cnt, $clog2(OVERSAMPLE).
- Sub-module: uart_sync2, the reset-to-1 two-flop synchronizer. It is reusable for CTS/RTS inputs.

Test Plan:
- Single byte, DATA_BITS=8, OVERSAMPLE=16, os_tick every 4 clk. Send 0xA5 as 8N1. Required: exactly one rx_valid pulse with rx_data=0xA5; busy high for the frame and low afterwards.
- Glitch filter: rx low for 5 os_ticks then high, then idle for 2 frames. Required: no pulse of any kind, busy returns to 0, state is IDLE.
- Framing error: send 0x3C with the stop bit driven 0. Required: frame_err pulses once, rx_valid=0, rx_data=0x3C. A following 0x11 with a correct stop bit gives rx_valid and 0x11.
- Back-to-back: 0x00 then 0xFF with no idle gap. Required: two rx_valid pulses with 0x00 and then 0xFF, and no frame_err.
- Reset mid-frame: assert arst_n low after the 3rd data bit of 0x5A, then release and send 0xC3. Required: all outputs at reset values during reset, no pulse for 0x5A, and rx_valid with 0xC3.
- With UART_RX_PARITY_EN, even parity: 0x07 with parity bit 1 gives rx_valid. 0x07 with parity bit 0 gives a parity_err pulse and no rx_valid.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and constants for the UART receive path.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int TICK_W         = $clog2(DEF_OVERSAMPLE);

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync2
// Brief    : Two-flop synchronizer for idle-high async inputs (RX, CTS, RTS).
// Revision : 1.0 - initial release
// ============================================================================
module uart_sync2 (
    input  logic clk,
    input  logic arst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Both stages reset high so a reset never looks like a start bit.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_deframer
// Brief    : Oversampling UART frame receiver, LSB first, one stop bit.
//            Define UART_RX_PARITY_EN to add a parity bit before the stop bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 os_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int TW = cnt_width(OVERSAMPLE);
    localparam int BW = cnt_width(DATA_BITS);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 8 ||
            (OVERSAMPLE % 2) != 0 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
            $error("uart_rx_deframer: illegal parameter value");
        end
    endgenerate

    logic rx_s;

    uart_sync2 u_sync (
        .clk    (clk),
        .arst_n (arst_n),
        .d      (rx),
        .q      (rx_s)
    );

    uart_state_e          state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 busy_q, busy_d;
    logic                 par_bad;

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    logic perr_q, perr_d;
    assign par_bad    = par_q != ((^shreg_q) ^ PARITY_ODD[0]);
    assign parity_err = perr_q;
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        if (os_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_d = ST_START;
                        tick_d  = '0;
                        busy_d  = 1'b1;
                    end
                end
                ST_START: begin
                    // Half-bit check both filters glitches and centres later samples.
                    if (tick_q == TICK_HALF) begin
                        tick_d = '0;
                        bit_d  = '0;
                        if (!rx_s) begin
                            state_d = ST_DATA;
                        end else begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (tick_q == TICK_LAST) begin
                        shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                        tick_d  = '0;
                        bit_d   = bit_q + BW'(1);
                        if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tick_q == TICK_LAST) begin
                        par_d   = rx_s;
                        tick_d  = '0;
                        state_d = ST_STOP;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (tick_q == TICK_LAST) begin
                        data_d  = shreg_q;
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        // A bad stop bit outranks a parity mismatch.
                        if (!rx_s) begin
                            ferr_d = 1'b1;
                        end else if (par_bad) begin
`ifdef UART_RX_PARITY_EN
                            perr_d = 1'b1;
`endif
                        end else begin
                            valid_d = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire
